// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches into the IR, then steps the ALU
// execute and register-file writeback strobes per opcode class.
module instr_sequencer #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    output logic [31:0]       ir,
    output logic [ADDR_W-1:0] pc,
    output logic              alu_en,
    output logic              alu_src_imm,
    output logic              rf_we,
    output logic              busy,
    output logic              halted,
    output logic              illegal_op
);

    localparam int unsigned OPC_W = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t           state;
    logic [OPC_W-1:0] opcode;

    assign opcode    = ir[31:25];
    assign imem_addr = pc;

    // Every output is updated together with the state it belongs to, so the
    // strobes are registered and aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            alu_en      <= 1'b0;
            rf_we       <= 1'b0;
            alu_src_imm <= 1'b0;
            imem_req    <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            alu_en <= 1'b0;
            rf_we  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_imm <= (opcode == OPC_W'(6)) || (opcode == OPC_W'(7));
                    if (opcode == OPC_W'(1)) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (opcode == OPC_W'(0) || opcode > OPC_W'(7)) begin
                        // Illegal opcodes retire as NOPs but leave a sticky flag.
                        if (opcode > OPC_W'(7)) begin
                            illegal_op <= 1'b1;
                        end
                        pc       <= pc + ADDR_W'(1);
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end else begin
                        alu_en <= 1'b1;
                        state  <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    rf_we <= 1'b1;
                    state <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    pc       <= pc + ADDR_W'(1);
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    if (start) begin
                        halted   <= 1'b0;
                        busy     <= 1'b1;
                        pc       <= '0;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                    busy     <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed and random programs checked cycle by
// cycle against a timeline built from the per-instruction latency rules.
module tb_instr_sequencer;

    localparam int LEN = 1100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic [31:0] ir;
    logic [7:0]  pc;
    logic        alu_en, alu_src_imm, rf_we, busy, halted, illegal_op;

    instr_sequencer #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .ir(ir), .pc(pc), .alu_en(alu_en), .alu_src_imm(alu_src_imm),
        .rf_we(rf_we), .busy(busy), .halted(halted), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [256];
    int unsigned waits [LEN];

    // Expected per-cycle timeline; cycle 0 is the first cycle after start is taken.
    logic        e_req [LEN], e_valid [LEN], e_alu [LEN], e_rf [LEN];
    logic        e_busy [LEN], e_halt [LEN], e_ill [LEN], e_imm [LEN];
    logic [7:0]  e_pc [LEN];
    logic [31:0] e_ir [LEN];
    int          e_end;

    // Architectural state carried between runs.
    logic [7:0]  m_pc = '0;
    logic [31:0] m_ir = '0;
    logic        m_ill = 1'b0, m_imm = 1'b0, m_halt = 1'b0;

    int alu_q [$];
    int rf_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input int c, input logic req, input logic valid, input logic alu,
                       input logic rf, input logic bsy, input logic hlt);
        if (c < LEN) begin
            e_req[c] = req;  e_valid[c] = valid; e_alu[c] = alu; e_rf[c] = rf;
            e_busy[c] = bsy; e_halt[c] = hlt;    e_pc[c] = m_pc; e_ir[c] = m_ir;
            e_ill[c] = m_ill; e_imm[c] = m_imm;
        end
    endtask

    // Instruction-level model: fetch takes waits+1 cycles, ALU ops add 3,
    // NOP/illegal add 1, HALT parks one cycle after its decode.
    task automatic build();
        int c = 0;
        int k = 0;
        logic [6:0] op;
        e_end = LEN;
        if (m_halt) m_pc = '0;
        m_halt = 1'b0;
        while (c < LEN) begin
            for (int i = 0; i <= int'(waits[k]); i++)
                put(c + i, 1'b1, i == int'(waits[k]), 1'b0, 1'b0, 1'b1, 1'b0);
            c += int'(waits[k]) + 1;
            k++;
            if (c >= LEN) break;
            m_ir = mem[m_pc];
            op = m_ir[31:25];
            put(c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            m_imm = (op == 7'd6) || (op == 7'd7);
            if (op == 7'd1) begin
                m_halt = 1'b1;
                for (int j = c + 1; j < LEN; j++) put(j, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                e_end = (c + 4 < LEN) ? c + 4 : LEN;
                break;
            end else if (op == 7'd0 || op > 7'd7) begin
                if (op > 7'd7) m_ill = 1'b1;
                m_pc = m_pc + 8'd1;
                c += 1;
            end else begin
                put(c + 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
                put(c + 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                m_pc = m_pc + 8'd1;
                c += 3;
            end
        end
    endtask

    task automatic check_cycle(input string tag, input int c);
        chk($sformatf("%s.imem_req@%0d", tag, c), 32'(imem_req), 32'(e_req[c]));
        chk($sformatf("%s.imem_addr@%0d", tag, c), 32'(imem_addr), 32'(e_pc[c]));
        chk($sformatf("%s.pc@%0d", tag, c), 32'(pc), 32'(e_pc[c]));
        chk($sformatf("%s.ir@%0d", tag, c), ir, e_ir[c]);
        chk($sformatf("%s.alu_en@%0d", tag, c), 32'(alu_en), 32'(e_alu[c]));
        chk($sformatf("%s.rf_we@%0d", tag, c), 32'(rf_we), 32'(e_rf[c]));
        chk($sformatf("%s.alu_src_imm@%0d", tag, c), 32'(alu_src_imm), 32'(e_imm[c]));
        chk($sformatf("%s.busy@%0d", tag, c), 32'(busy), 32'(e_busy[c]));
        chk($sformatf("%s.halted@%0d", tag, c), 32'(halted), 32'(e_halt[c]));
        chk($sformatf("%s.illegal_op@%0d", tag, c), 32'(illegal_op), 32'(e_ill[c]));
    endtask

    // Start from IDLE/HALT, then drive memory and stray start/valid per the timeline.
    task automatic run(input string tag);
        build();
        alu_q.delete();
        rf_q.delete();
        start = 1'b1;
        imem_valid = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < e_end; c++) begin
            check_cycle(tag, c);
            if (alu_en) alu_q.push_back(c);
            if (rf_we) rf_q.push_back(c);
            start = e_halt[c] ? 1'b0 : 1'($urandom_range(0, 1));
            if (e_req[c]) begin
                imem_valid = e_valid[c];
                imem_rdata = e_valid[c] ? mem[e_pc[c]] : $urandom;
            end else begin
                imem_valid = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        imem_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        start = 1'b0;
        imem_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
        rst = 1'b0;
        m_pc = '0; m_ir = '0; m_ill = 1'b0; m_imm = 1'b0; m_halt = 1'b0;
    endtask

    task automatic set_waits(input int maxw);
        for (int i = 0; i < LEN; i++) waits[i] = $urandom_range(0, maxw);
    endtask

    task automatic rand_prog(input int halt_pct);
        for (int a = 0; a < 256; a++) begin
            int r;
            logic [6:0] op;
            r = $urandom_range(0, 99);
            if (r < halt_pct)  op = 7'd1;
            else if (r < 45)   op = 7'($urandom_range(2, 7));
            else if (r < 75)   op = 7'd0;
            else if (r < 85)   op = 7'($urandom_range(8, 127));
            else               op = 7'($urandom_range(2, 7));
            mem[a] = {op, 25'($urandom)};
        end
    endtask

    initial begin
        bit found;

        // Reset and idle: nothing moves without start, stray valid ignored.
        do_reset(2);
        for (int c = 0; c < 10; c++) begin
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            chk($sformatf("idle.imem_req@%0d", c), 32'(imem_req), 32'd0);
            chk($sformatf("idle.pc@%0d", c), 32'(pc), 32'd0);
            chk($sformatf("idle.ir@%0d", c), ir, 32'd0);
            chk($sformatf("idle.strobes@%0d", c),
                32'({alu_en, rf_we, alu_src_imm, busy, halted, illegal_op}), 32'd0);
            @(posedge clk); #1;
        end
        imem_valid = 1'b0;

        // Straight-line program, zero wait states.
        for (int a = 0; a < 256; a++) mem[a] = 32'h0200_0000;
        mem[0] = 32'h0400_0000 | (32'd5 << 20) | (32'd3 << 15) | (32'd9 << 10);
        mem[1] = 32'h0C00_0000 | 32'h0000_1234;
        mem[2] = 32'h0200_0000;
        set_waits(0);
        run("straight");
        chk("straight.alu_count", 32'(alu_q.size()), 32'd2);
        chk("straight.alu_first", 32'(alu_q[0]), 32'd2);
        chk("straight.alu_second", 32'(alu_q[1]), 32'd6);
        chk("straight.rf_first", 32'(rf_q[0]), 32'd3);
        chk("straight.rf_second", 32'(rf_q[1]), 32'd7);
        chk("straight.halted", 32'(halted), 32'd1);
        chk("straight.pc", 32'(pc), 32'd2);

        // Restart from HALT: fetch resumes at 0, straight into the same program.
        run("restart");
        chk("restart.pc", 32'(pc), 32'd2);

        // Three wait states per fetch: one ALU instruction spans 7 cycles.
        do_reset(1);
        mem[0] = 32'h0600_0000;
        mem[1] = 32'h0200_0000;
        set_waits(0);
        for (int i = 0; i < LEN; i++) waits[i] = 3;
        run("waits");
        chk("waits.alu_at", 32'(alu_q[0]), 32'd5);
        chk("waits.rf_at", 32'(rf_q[0]), 32'd6);
        chk("waits.halt_pc", 32'(pc), 32'd1);

        // NOP then illegal then HALT.
        do_reset(1);
        mem[0] = 32'h0000_0000;
        mem[1] = 32'hFE00_0000;
        mem[2] = 32'h0200_0000;
        set_waits(0);
        run("nopill");
        chk("nopill.alu_count", 32'(alu_q.size()), 32'd0);
        chk("nopill.rf_count", 32'(rf_q.size()), 32'd0);
        chk("nopill.illegal", 32'(illegal_op), 32'd1);
        chk("nopill.halt_pc", 32'(pc), 32'd2);
        chk("nopill.halted", 32'(halted), 32'd1);

        // PC wrap: all NOPs run past 255 back to 0 without halting.
        do_reset(1);
        for (int a = 0; a < 256; a++) mem[a] = 32'h0000_0000;
        set_waits(0);
        run("wrap");
        chk("wrap.no_halt", 32'(halted), 32'd0);

        // Random programs with random wait states.
        for (int t = 0; t < 6; t++) begin
            if (!m_halt) do_reset(1 + t % 2);
            rand_prog(t < 3 ? 3 : 0);
            set_waits(3);
            run($sformatf("rand%0d", t));
        end

        // Reset asserted during EXECUTE returns everything to idle at once.
        do_reset(1);
        mem[0] = 32'h0E00_0000;
        set_waits(0);
        start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            imem_valid = imem_req;
            imem_rdata = mem[0];
            @(posedge clk); #1;
            start = 1'b0;
            if (alu_en) found = 1'b1;
        end
        chk("midrst.reached_execute", 32'(found), 32'd1);
        rst = 1'b1;
        imem_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst.alu_en", 32'(alu_en), 32'd0);
        chk("midrst.rf_we", 32'(rf_we), 32'd0);
        chk("midrst.pc", 32'(pc), 32'd0);
        chk("midrst.ir", ir, 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.imem_req", 32'(imem_req), 32'd0);
        chk("midrst.halted", 32'(halted), 32'd0);
        chk("midrst.alu_src_imm", 32'(alu_src_imm), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst.idle_hold", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
